apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_pkg.sv | 23 ++
 rtl/apb_timeout_cnt.sv | 38 +++
 rtl/apb_master.sv | 122 ++++++++++++
 tb/tb_apb_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master: FSM states, default widths,
// the default timeout, and the register map of the ALU slave it is paired with.
package apb_master_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = 8;

    // ALU slave register byte offsets
    localparam int ALU_A_OFS      = 0;
    localparam int ALU_B_OFS      = 4;
    localparam int ALU_RESULT_OFS = 8;
    localparam int ALU_CMD_OFS    = 12;
    localparam int ALU_EN_OFS     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting on pready; expired_o flags the wait cycle
// whose increment would bring the count up to TIMEOUT.
module apb_timeout_cnt
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looking one increment ahead lets the FSM abort on exactly the TIMEOUT-th wait.
    assign expired_o = inc_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: a request is latched in IDLE, driven through
// SETUP and ACCESS, and reported with a one-cycle rsp_valid pulse (or a timeout).
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e        state_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic cnt_clear;
    logic cnt_inc;
    logic cnt_expired;

    assign cnt_clear = (state_q == ST_IDLE) && req_valid;
    assign cnt_inc   = (state_q == ST_ACCESS) && !pready;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i     (pclk),
        .rst_ni    (presetn),
        .clear_i   (cnt_clear),
        .inc_i     (cnt_inc),
        .expired_o (cnt_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        pwrite_q <= req_write;
                        paddr_q  <= req_addr;
                        pwdata_q <= req_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready is checked first so a completion on the last allowed cycle wins.
                    if (pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        if (!pwrite_q) begin
                            rsp_rdata_q <= prdata;
                        end
                        state_q <= ST_IDLE;
                    end else if (cnt_expired) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: an ALU-style slave modelled as a word array, with each
// transfer's expected cycle shape and response derived from its wait count.
module tb_apb_master;
    import apb_master_pkg::*;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          pclk;
    logic          presetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    // clock / watchdog
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // scoreboard state: expected {err, rdata} per issued transfer
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] mem [0:7];
    int            vectors;
    int            fails;

    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    int            r_waits;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave read: RESULT is computed from A, B, CMD when EN is set.
    function automatic logic [DW-1:0] slave_read(input logic [AW-1:0] a);
        logic [DW-1:0] av;
        logic [DW-1:0] bv;
        av = mem[ALU_A_OFS / 4];
        bv = mem[ALU_B_OFS / 4];
        if (int'(a[4:2]) == ALU_RESULT_OFS / 4) begin
            if (mem[ALU_EN_OFS / 4][0] == 1'b0) return '0;
            case (mem[ALU_CMD_OFS / 4][1:0])
                2'd0:    return av + bv;
                2'd1:    return av - bv;
                2'd2:    return av & bv;
                default: return av ^ bv;
            endcase
        end
        return mem[a[4:2]];
    endfunction

    // One transfer; waits = pready-low ACCESS cycles before pready, >= TMO means never ready.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int waits, input logic stale);
        int        acc;
        logic      timed_out;
        logic      rdy;
        logic [DW:0] got;
        timed_out = (waits >= TMO);
        acc = timed_out ? TMO : waits + 1;
        if (timed_out)  exp_q.push_back({1'b1, {DW{1'b0}}});
        else if (wr)    exp_q.push_back({1'b0, last_rdata});
        else            exp_q.push_back({1'b0, slave_read(addr)});

        @(negedge pclk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("idle_psel", 64'(psel), 64'd0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        pready    = stale;
        prdata    = $urandom;

        for (int n = 1; n <= acc + 2; n++) begin
            @(negedge pclk);
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
            if (n <= acc + 1) begin
                chk("psel_busy", 64'(psel), 64'd1);
                chk("penable", 64'(penable), 64'(n >= 2));
                chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
                chk("req_ready_busy", 64'(req_ready), 64'd0);
                chk("paddr", 64'(paddr), 64'(addr));
                chk("pwrite", 64'(pwrite), 64'(wr));
                chk("pwdata", 64'(pwdata), 64'(wd));
            end else begin
                chk("rsp_valid", 64'(rsp_valid), 64'd1);
                chk("psel_done", 64'(psel), 64'd0);
                chk("penable_done", 64'(penable), 64'd0);
                chk("req_ready_done", 64'(req_ready), 64'd1);
                got = exp_q.pop_front();
                chk("rsp_err", 64'(rsp_err), 64'(got[DW]));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(got[DW-1:0]));
                last_rdata = got[DW-1:0];
            end
            if (n >= 2 && n <= acc + 1) begin
                rdy    = !timed_out && (n - 1 == waits + 1);
                pready = rdy;
                prdata = (rdy && !wr) ? slave_read(addr) : $urandom;
                if (rdy && wr) mem[addr[4:2]] = wd;
            end else begin
                pready = stale;
                prdata = $urandom;
            end
        end

        @(negedge pclk);
        chk("rsp_valid_one_cycle", 64'(rsp_valid), 64'd0);
        chk("rsp_rdata_hold", 64'(rsp_rdata), 64'(last_rdata));
        chk("rsp_err_hold", 64'(rsp_err), 64'(timed_out));
        chk("paddr_hold", 64'(paddr), 64'(addr));
    endtask

    initial begin
        vectors    = 0;
        fails      = 0;
        last_rdata = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;

        // reset state
        #12;
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // zero-wait write with pready tied high
        xfer(1'b1, 5'd4, 32'h3, 0, 1'b1);

        // ALU slave: one wait per transfer, then read RESULT
        xfer(1'b1, 5'(ALU_A_OFS),   32'd5, 1, 1'b0);
        xfer(1'b1, 5'(ALU_B_OFS),   32'd3, 1, 1'b0);
        xfer(1'b1, 5'(ALU_CMD_OFS), 32'd0, 1, 1'b0);
        xfer(1'b1, 5'(ALU_EN_OFS),  32'd1, 1, 1'b0);
        xfer(1'b0, 5'(ALU_RESULT_OFS), 32'h0, 1, 1'b0);
        chk("alu_result", 64'(rsp_rdata), 64'd8);

        // timeout, then pready on the last allowed ACCESS cycle
        xfer(1'b0, 5'd0, 32'h0, TMO, 1'b0);
        chk("timeout_rdata_zero", 64'(rsp_rdata), 64'd0);
        xfer(1'b0, 5'(ALU_RESULT_OFS), 32'h0, TMO - 1, 1'b0);
        chk("race_rdata", 64'(rsp_rdata), 64'd8);

        // stale pready across back-to-back reads
        xfer(1'b0, 5'd0, 32'h0, 0, 1'b1);
        xfer(1'b0, 5'd4, 32'h0, 0, 1'b1);

        // randomized transfers, biased toward the timeout boundary
        for (int i = 0; i < 16; i++) begin
            r_wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) r_addr = AW'($urandom);
            else r_addr = AW'($urandom_range(0, 4) * 4);
            r_data = (int'(r_addr) == ALU_CMD_OFS) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            if ($urandom_range(0, 3) == 0) r_waits = TMO - 1 + $urandom_range(0, 1);
            else r_waits = $urandom_range(0, 4);
            xfer(r_wr, r_addr, r_data, r_waits, 1'($urandom_range(0, 1)));
        end

        // reset during ACCESS
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'd4;
        req_wdata = 32'hdead_beef;
        pready    = 1'b0;
        @(negedge pclk);
        req_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("mid_access_psel", 64'(psel), 64'd1);
        chk("mid_access_penable", 64'(penable), 64'd1);
        presetn = 1'b0;
        #1;
        chk("async_rst_psel", 64'(psel), 64'd0);
        chk("async_rst_penable", 64'(penable), 64'd0);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_paddr", 64'(paddr), 64'd0);
        chk("async_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        last_rdata = '0;
        @(negedge pclk);
        presetn = 1'b1;
        pready  = 1'b1;
        @(posedge pclk);
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("abort_no_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("abort_idle_psel", 64'(psel), 64'd0);
        end
        pready = 1'b0;

        // function resumes after the aborted transfer
        xfer(1'b0, 5'(ALU_RESULT_OFS), 32'h0, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
